// File: rtl/block_emitter.sv
// Serialises begin/end commands into an ASCII stream ("begin " / "end "), one byte per cycle.
// Latency: first character one cycle after the command is accepted; back-to-back words have no gap.
// Backpressure: cmd_ready is high only in IDLE or on a trailing-space cycle; rejected commands are consumed.
module block_emitter #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic               cmd,
    output logic               cmd_ready,
    output logic               out_valid,
    output logic [7:0]         out,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic               balanced
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        B_B  = 4'd1,
        B_E  = 4'd2,
        B_G  = 4'd3,
        B_I  = 4'd4,
        B_N  = 4'd5,
        B_SP = 4'd6,
        E_E  = 4'd7,
        E_N  = 4'd8,
        E_D  = 4'd9,
        E_SP = 4'd10
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               error_nxt;
    logic               accept;

    // State, depth and sticky error registers; reset abandons any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            depth <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            depth <= depth_nxt;
            error <= error_nxt;
        end
    end

    assign accept = cmd_valid && cmd_ready;

    // Next-state: walk the current word, and on a completed handshake either start a new word or flag a rejection.
    always_comb begin
        state_nxt = IDLE;
        depth_nxt = depth;
        error_nxt = error;
        case (state)
            B_B:     state_nxt = B_E;
            B_E:     state_nxt = B_G;
            B_G:     state_nxt = B_I;
            B_I:     state_nxt = B_N;
            B_N:     state_nxt = B_SP;
            E_E:     state_nxt = E_N;
            E_N:     state_nxt = E_D;
            E_D:     state_nxt = E_SP;
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            if (cmd) begin
                if (depth != DEPTH_MAX) begin
                    state_nxt = B_B;
                    depth_nxt = depth + DEPTH_ONE;
                end else begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                end
            end else begin
                if (depth != '0) begin
                    state_nxt = E_E;
                    depth_nxt = depth - DEPTH_ONE;
                end else begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                end
            end
        end
    end

    // Output decode depends on registered state only, so nothing follows cmd/cmd_valid combinationally.
    always_comb begin
        out       = 8'h00;
        out_valid = (state != IDLE);
        cmd_ready = (state == IDLE) || (state == B_SP) || (state == E_SP);
        case (state)
            B_B:     out = 8'h62;
            B_E:     out = 8'h65;
            B_G:     out = 8'h67;
            B_I:     out = 8'h69;
            B_N:     out = 8'h6E;
            E_E:     out = 8'h65;
            E_N:     out = 8'h6E;
            E_D:     out = 8'h64;
            B_SP:    out = 8'h20;
            E_SP:    out = 8'h20;
            default: out = 8'h00;
        endcase
    end

    assign balanced = (depth == '0) && !error;

endmodule

// File: tb/tb_block_emitter.sv
// Self-checking bench for block_emitter: vector table, hand sequences, DEPTH_W=2 saturation, loopback parse.
// Stimulus driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_block_emitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd = 1'b0;
    logic       cmd_ready, out_valid, error, balanced;
    logic [7:0] out;
    logic [7:0] depth;

    logic       v2 = 1'b0;
    logic       c2 = 1'b0;
    logic       rdy2, ov2, e2, bal2;
    logic [7:0] o2;
    logic [1:0] d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_emitter #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .out_valid(out_valid), .out(out),
        .depth(depth), .error(error), .balanced(balanced)
    );

    block_emitter #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(v2), .cmd(c2),
        .cmd_ready(rdy2), .out_valid(ov2), .out(o2),
        .depth(d2), .error(e2), .balanced(bal2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        v2 = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic apply(input logic v, input logic c);
        @(negedge clk);
        cmd_valid = v;
        cmd = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply2(input logic v, input logic c);
        @(negedge clk);
        v2 = v;
        c2 = c;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit       rst;
        bit       v;
        bit       c;
        bit       ov;
        bit [7:0] o;
        bit [7:0] d;
        bit       e;
        bit       rdy;
        bit       bal;
    } vec_t;

    vec_t tbl[$];

    bit       cmdq[$];
    bit [7:0] rxq[$];
    bit [7:0] expq[$];
    int       depq[$];

    task automatic push_word(input bit b);
        if (b) begin
            expq.push_back(8'h62); expq.push_back(8'h65); expq.push_back(8'h67);
            expq.push_back(8'h69); expq.push_back(8'h6E); expq.push_back(8'h20);
        end else begin
            expq.push_back(8'h65); expq.push_back(8'h6E); expq.push_back(8'h64);
            expq.push_back(8'h20);
        end
    endtask

    // Streams cmdq with cmd_valid held whenever commands remain; collects bytes, depths after acceptances,
    // and checks cmd_ready is only high on idle/space cycles. Reports whether the valid bytes were contiguous.
    task automatic run_cmds(input string name, output bit contiguous);
        int idx = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        int bad_rdy = 0;
        bit acc;
        bit done = 0;
        rxq.delete();
        depq.delete();
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cmd_valid = (idx < cmdq.size());
            cmd = (idx < cmdq.size()) ? cmdq[idx] : 1'b0;
            acc = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                idx++;
                depq.push_back(int'(depth));
            end
            if (cmd_ready != (!out_valid || out == 8'h20)) bad_rdy++;
            if (out_valid) begin
                rxq.push_back(out);
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (idx == cmdq.size() && !out_valid) done = 1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({name, " completes within budget"}, int'(done), 1);
        chk({name, " cmd_ready only idle/space"}, bad_rdy, 0);
        contiguous = (first >= 0) && (rxq.size() == last - first + 1);
    endtask

    task automatic chk_stream(input string name);
        int mism = -1;
        if (rxq.size() != expq.size()) mism = 9999;
        else
            for (int i = 0; i < rxq.size(); i++)
                if (mism < 0 && rxq[i] != expq[i]) mism = i;
        checks++;
        if (mism >= 0) begin
            errors++;
            $display("FAIL %s: got %0d bytes, expected %0d bytes (first bad index %0d)",
                     name, rxq.size(), expq.size(), mism);
        end
    endtask

    // Independent checker model: parses space-separated words, requires only begin/end and never-negative nesting.
    function automatic bit check_blocks();
        bit [7:0] w[$];
        int lvl = 0;
        bit ok = 1;
        for (int i = 0; i < rxq.size(); i++) begin
            if (rxq[i] == 8'h20) begin
                if (w.size() == 5 && w[0] == 8'h62 && w[1] == 8'h65 && w[2] == 8'h67 &&
                    w[3] == 8'h69 && w[4] == 8'h6E) lvl++;
                else if (w.size() == 3 && w[0] == 8'h65 && w[1] == 8'h6E && w[2] == 8'h64) begin
                    lvl--;
                    if (lvl < 0) ok = 0;
                end else ok = 0;
                w.delete();
            end else w.push_back(rxq[i]);
        end
        if (w.size() != 0 || lvl != 0) ok = 0;
        return ok;
    endfunction

    initial begin
        bit contig;
        bit [7:0] letters [6];
        int lvl, rem, n, quiet;

        // Test 1 (single begin) and test 3 (end at depth 0, then begin), each row checked after its clock edge.
        letters[0] = 8'h62; letters[1] = 8'h65; letters[2] = 8'h67;
        letters[3] = 8'h69; letters[4] = 8'h6E; letters[5] = 8'h20;
        tbl.push_back('{1, 1, 1, 1, letters[0], 8'd1, 0, 0, 0});
        for (int i = 1; i < 6; i++)
            tbl.push_back('{0, 0, 0, 1, letters[i], 8'd1, 0, (i == 5), 0});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 8'd1, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 8'h00, 8'd0, 1, 1, 0});
        tbl.push_back('{0, 1, 1, 1, letters[0], 8'd1, 1, 0, 0});
        for (int i = 1; i < 6; i++)
            tbl.push_back('{0, 0, 0, 1, letters[i], 8'd1, 1, (i == 5), 0});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 8'd1, 1, 1, 0});

        #3;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out", int'(out), 0);
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset balanced", int'(balanced), 1);
        chk("reset depth", int'(depth), 0);
        chk("reset error", int'(error), 0);
        reset = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) do_reset();
            apply(tbl[r].v, tbl[r].c);
            chk($sformatf("row%0d out_valid", r), int'(out_valid), int'(tbl[r].ov));
            chk($sformatf("row%0d out", r), int'(out), int'(tbl[r].o));
            chk($sformatf("row%0d depth", r), int'(depth), int'(tbl[r].d));
            chk($sformatf("row%0d error", r), int'(error), int'(tbl[r].e));
            chk($sformatf("row%0d cmd_ready", r), int'(cmd_ready), int'(tbl[r].rdy));
            chk($sformatf("row%0d balanced", r), int'(balanced), int'(tbl[r].bal));
        end

        // Test 2: begin begin end end held valid -> 20 contiguous bytes, depths 1,2,1,0.
        do_reset();
        cmdq = '{1, 1, 0, 0};
        expq.delete();
        foreach (cmdq[i]) push_word(cmdq[i]);
        run_cmds("b2e2", contig);
        chk_stream("b2e2 stream");
        chk("b2e2 contiguous", int'(contig), 1);
        chk("b2e2 acceptances", depq.size(), 4);
        if (depq.size() == 4) begin
            chk("b2e2 depth0", depq[0], 1);
            chk("b2e2 depth1", depq[1], 2);
            chk("b2e2 depth2", depq[2], 1);
            chk("b2e2 depth3", depq[3], 0);
        end
        chk("b2e2 balanced", int'(balanced), 1);

        // Test 4: asynchronous reset while in B_G, then an end must be rejected.
        do_reset();
        apply(1, 1);
        apply(0, 0);
        apply(0, 0);
        chk("pre-reset out is g", int'(out), 8'h67);
        #2 reset = 1'b1;
        #1;
        chk("async rst out_valid", int'(out_valid), 0);
        chk("async rst out", int'(out), 0);
        chk("async rst depth", int'(depth), 0);
        chk("async rst error", int'(error), 0);
        reset = 1'b0;
        apply(1, 0);
        chk("post-rst end error", int'(error), 1);
        chk("post-rst end out_valid", int'(out_valid), 0);
        chk("post-rst end depth", int'(depth), 0);

        // Test 5: DEPTH_W=2 saturates at 3; the fourth begin is rejected and emits nothing.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply2(1, 1);
            for (int j = 0; j < 6; j++) apply2(0, 0);
        end
        chk("w2 depth after 3 begins", int'(d2), 3);
        chk("w2 no error yet", int'(e2), 0);
        apply2(1, 1);
        chk("w2 4th begin error", int'(e2), 1);
        chk("w2 4th begin depth", int'(d2), 3);
        chk("w2 4th begin out_valid", int'(ov2), 0);
        quiet = 0;
        for (int j = 0; j < 4; j++) begin
            apply2(0, 0);
            if (ov2) quiet++;
        end
        chk("w2 no bytes after reject", quiet, 0);
        chk("w2 balanced", int'(bal2), 0);

        // Test 6: random legal sequence ending at depth 0, looped into a checker model.
        do_reset();
        cmdq.delete();
        expq.delete();
        lvl = 0;
        n = 24;
        for (int i = 0; i < n; i++) begin
            rem = n - i;
            if (lvl == 0) cmdq.push_back(1);
            else if (lvl >= rem) cmdq.push_back(0);
            else cmdq.push_back($urandom_range(1, 0) == 1);
            lvl += cmdq[i] ? 1 : -1;
        end
        foreach (cmdq[i]) push_word(cmdq[i]);
        run_cmds("loop", contig);
        chk_stream("loop stream");
        chk("loop checker result", int'(check_blocks()), 1);
        chk("loop balanced", int'(balanced), 1);
        chk("loop error", int'(error), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
